// File: rtl/ps2_key_receiver.sv
// PS/2 Set 2 keyboard receiver: pin sync/filter, 11-bit frame deserialiser, make/break/extended prefix tracking, button-code lookup.
// Optional idle-clock watchdog is built when PS2_TIMEOUT_EN is defined.
module ps2_key_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_dec,
    output logic       key_valid,
    output logic       frame_err
);
    // state   | meaning
    // IDLE    | no prefix pending
    // EXT     | 0xE0 seen, next byte is an extended make (or 0xF0)
    // BRK     | 0xF0 seen, next byte is a non-extended break
    // EXT_BRK | 0xE0 0xF0 seen, next byte is an extended break
    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FILT_LOAD = FW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic [FW-1:0]          r_filt_cnt;
    logic                   r_filt_clk;
    logic                   r_strobe;
    logic [3:0]             r_bit_cnt;
    logic [10:0]            r_shift;
    logic                   r_frame_done;
    state_t                 r_state;
    state_t                 w_state_nxt;

    logic       w_clk_s;
    logic       w_data_s;
    logic       w_frame_ok;
    logic       w_byte_rdy;
    logic       w_bad;
    logic       w_timeout;
    logic       w_lookup_en;
    logic       w_is_break;
    logic       w_is_ext;
    logic [7:0] w_byte;
    logic [7:0] w_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];

    // Down-counter reloads on any sample matching the filtered level; toggle on terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= FILT_LOAD;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= FILT_LOAD;
            end else if (r_filt_cnt == '0) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= FILT_LOAD;
                r_strobe   <= ~w_clk_s;
            end else begin
                r_filt_cnt <= r_filt_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 11'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_timeout) begin
                r_bit_cnt <= 4'd0;
            end else if (r_strobe) begin
                r_shift <= {w_data_s, r_shift[10:1]};
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt    <= 4'd0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    assign w_byte     = r_shift[8:1];
    assign w_frame_ok = ~r_shift[0] & r_shift[10] & (^r_shift[9:1]);
    assign w_byte_rdy = r_frame_done & w_frame_ok;
    assign w_bad      = r_frame_done & ~w_frame_ok;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_strobe || (r_bit_cnt == 4'd0) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lookup_en = 1'b0;
        w_is_break  = 1'b0;
        w_is_ext    = 1'b0;
        if (w_bad || w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_byte_rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (w_byte == 8'hE0)      w_state_nxt = S_EXT;
                    else if (w_byte == 8'hF0) w_state_nxt = S_BRK;
                    else                      w_lookup_en = 1'b1;
                end
                S_EXT: begin
                    if (w_byte == 8'hF0) begin
                        w_state_nxt = S_EXT_BRK;
                    end else begin
                        w_lookup_en = 1'b1;
                        w_is_ext    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_BRK: begin
                    w_lookup_en = 1'b1;
                    w_is_break  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    w_lookup_en = 1'b1;
                    w_is_break  = 1'b1;
                    w_is_ext    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Keypad 8 (non-extended 0x75) deliberately falls through to unmapped.
    always_comb begin
        w_code = 8'h00;
        if (w_is_ext) begin
            case (w_byte)
                8'h75:   w_code = 8'h05;
                8'h72:   w_code = 8'h06;
                8'h6B:   w_code = 8'h07;
                8'h74:   w_code = 8'h08;
                default: w_code = 8'h00;
            endcase
        end else begin
            case (w_byte)
                8'h1A:   w_code = 8'h01;
                8'h1C:   w_code = 8'h02;
                8'h22:   w_code = 8'h09;
                8'h1B:   w_code = 8'h0A;
                default: w_code = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_dec   <= 8'h00;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= w_bad | w_timeout;
            if (w_lookup_en && (w_code != 8'h00)) begin
                if (!w_is_break && (w_code != key_dec)) begin
                    key_dec   <= w_code;
                    key_valid <= 1'b1;
                end else if (w_is_break && (w_code == key_dec)) begin
                    key_dec   <= 8'h00;
                    key_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed self-checking bench for ps2_key_receiver: frames, prefixes, errors, glitch rejection, truncation and reset.
module tb_ps2_key_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_dec;
    logic       key_valid;
    logic       frame_err;

    int n_cmp = 0;
    int n_mis = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [9:1] vtr;
    logic [9:1] etr;

    localparam logic [9:1] AT_CYCLE8 = 9'b010000000;

    always #5 clk = ~clk;

    ps2_key_receiver #(
        .SYNC_STAGES(2),
        .FILTER_LEN(4),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .key_dec(key_dec),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always @(negedge clk) begin
        if (key_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1) n_err++;
    end

    function automatic logic [10:0] mk(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Trace of key_valid/frame_err sampled after each of the 9 clk edges following the stop-bit fall.
    task automatic send_bits(input logic [10:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                for (int k = 1; k <= 9; k++) begin
                    @(negedge clk);
                    vtr[k] = key_valid;
                    etr[k] = frame_err;
                end
                repeat (11) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
            ps2_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] d);
        send_bits(mk(d), 0, 10);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (key_dec !== 8'h00) begin n_mis++; $display("FAIL reset_key_dec: got %h expected 00", key_dec); end
        n_cmp++; if (key_valid !== 1'b0) begin n_mis++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_mis++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make_a;
        int bv;
        bv = n_valid;
        send(8'h1C);
        n_cmp++; if (key_dec !== 8'h02) begin n_mis++; $display("FAIL make_a_key: got %h expected 02", key_dec); end
        n_cmp++; if (vtr !== AT_CYCLE8) begin n_mis++; $display("FAIL make_a_valid_timing: got %b expected %b", vtr, AT_CYCLE8); end
        n_cmp++; if (etr !== 9'b0) begin n_mis++; $display("FAIL make_a_err: got %b expected 000000000", etr); end
        n_cmp++; if (n_valid - bv != 1) begin n_mis++; $display("FAIL make_a_pulses: got %0d expected 1", n_valid - bv); end
    endtask

    task automatic test_extended;
        int bv;
        bv = n_valid;
        send(8'hE0); send(8'h75);
        n_cmp++; if (key_dec !== 8'h05) begin n_mis++; $display("FAIL ext_up_make: got %h expected 05", key_dec); end
        send(8'hE0); send(8'hF0); send(8'h75);
        n_cmp++; if (key_dec !== 8'h00) begin n_mis++; $display("FAIL ext_up_break: got %h expected 00", key_dec); end
        n_cmp++; if (n_valid - bv != 2) begin n_mis++; $display("FAIL ext_pulses: got %0d expected 2", n_valid - bv); end
    endtask

    task automatic test_parity;
        int bv, be;
        logic [10:0] f;
        bv = n_valid; be = n_err;
        f = mk(8'h22) ^ 11'h200;
        send_bits(f, 0, 10);
        n_cmp++; if (etr !== AT_CYCLE8) begin n_mis++; $display("FAIL parity_err_timing: got %b expected %b", etr, AT_CYCLE8); end
        n_cmp++; if (n_err - be != 1) begin n_mis++; $display("FAIL parity_err_count: got %0d expected 1", n_err - be); end
        n_cmp++; if (key_dec !== 8'h00) begin n_mis++; $display("FAIL parity_key_kept: got %h expected 00", key_dec); end
        n_cmp++; if (n_valid != bv) begin n_mis++; $display("FAIL parity_no_pulse: got %0d expected 0", n_valid - bv); end
        send(8'h22);
        n_cmp++; if (key_dec !== 8'h09) begin n_mis++; $display("FAIL parity_recover: got %h expected 09", key_dec); end
    endtask

    task automatic test_stop_and_prefix;
        int bv, be;
        logic [10:0] f;
        be = n_err; bv = n_valid;
        f = mk(8'h1C);
        f[10] = 1'b0;
        send_bits(f, 0, 10);
        n_cmp++; if (n_err - be != 1) begin n_mis++; $display("FAIL stop_err_count: got %0d expected 1", n_err - be); end
        n_cmp++; if (key_dec !== 8'h09) begin n_mis++; $display("FAIL stop_key_kept: got %h expected 09", key_dec); end
        // a bad frame after 0xF0 must drop the break prefix, so the following 0x22 is a repeat make
        send(8'hF0);
        send_bits(mk(8'h1A) ^ 11'h200, 0, 10);
        send(8'h22);
        n_cmp++; if (key_dec !== 8'h09 || n_valid != bv) begin n_mis++; $display("FAIL prefix_cleared: got %h/%0d expected 09/0", key_dec, n_valid - bv); end
    endtask

    task automatic test_hold;
        int bv;
        bv = n_valid;
        send(8'h1C); send(8'h1C); send(8'h1C);
        n_cmp++; if (key_dec !== 8'h02) begin n_mis++; $display("FAIL hold_key: got %h expected 02", key_dec); end
        n_cmp++; if (n_valid - bv != 1) begin n_mis++; $display("FAIL hold_pulses: got %0d expected 1", n_valid - bv); end
        send(8'hF0); send(8'h1A);
        n_cmp++; if (key_dec !== 8'h02 || n_valid - bv != 1) begin n_mis++; $display("FAIL other_break_ignored: got %h/%0d expected 02/1", key_dec, n_valid - bv); end
        send(8'h75);
        n_cmp++; if (key_dec !== 8'h02 || n_valid - bv != 1) begin n_mis++; $display("FAIL keypad8_unmapped: got %h/%0d expected 02/1", key_dec, n_valid - bv); end
        send(8'hF0); send(8'h1C);
        n_cmp++; if (key_dec !== 8'h00) begin n_mis++; $display("FAIL hold_release: got %h expected 00", key_dec); end
        n_cmp++; if (n_valid - bv != 2) begin n_mis++; $display("FAIL hold_release_pulses: got %0d expected 2", n_valid - bv); end
    endtask

    task automatic test_glitch;
        int bv, be;
        logic [10:0] f;
        bv = n_valid; be = n_err;
        f = mk(8'h1B);
        send_bits(f, 0, 3);
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        send_bits(f, 4, 10);
        n_cmp++; if (key_dec !== 8'h0A) begin n_mis++; $display("FAIL glitch_key: got %h expected 0A", key_dec); end
        n_cmp++; if (n_err != be) begin n_mis++; $display("FAIL glitch_err: got %0d expected 0", n_err - be); end
        n_cmp++; if (n_valid - bv != 1) begin n_mis++; $display("FAIL glitch_pulses: got %0d expected 1", n_valid - bv); end
    endtask

    task automatic test_truncated;
        int be;
        logic [10:0] f;
        be = n_err;
        f = mk(8'h1A);
        send_bits(f, 0, 4);
        repeat (300) @(negedge clk);
`ifdef PS2_TIMEOUT_EN
        n_cmp++; if (n_err - be != 1) begin n_mis++; $display("FAIL timeout_err: got %0d expected 1", n_err - be); end
        send_bits(f, 0, 10);
`else
        n_cmp++; if (n_err != be) begin n_mis++; $display("FAIL pending_no_err: got %0d expected 0", n_err - be); end
        send_bits(f, 5, 10);
`endif
        n_cmp++; if (key_dec !== 8'h01) begin n_mis++; $display("FAIL truncated_then_z: got %h expected 01", key_dec); end
    endtask

    task automatic test_reset_mid;
        int bv;
        send_bits(mk(8'h1C), 0, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (key_dec !== 8'h00) begin n_mis++; $display("FAIL midreset_key: got %h expected 00", key_dec); end
        n_cmp++; if (key_valid !== 1'b0 || frame_err !== 1'b0) begin n_mis++; $display("FAIL midreset_pulses: got %b%b expected 00", key_valid, frame_err); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'hE0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        bv = n_valid;
        send(8'h75);
        n_cmp++; if (key_dec !== 8'h00 || n_valid != bv) begin n_mis++; $display("FAIL prefix_dropped_by_reset: got %h/%0d expected 00/0", key_dec, n_valid - bv); end
        send(8'h1A);
        n_cmp++; if (key_dec !== 8'h01) begin n_mis++; $display("FAIL after_reset_frame: got %h expected 01", key_dec); end
    endtask

    initial begin
        test_reset();
        test_make_a();
        test_extended();
        test_parity();
        test_stop_and_prefix();
        test_hold();
        test_glitch();
        test_truncated();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
